cv32e40p_wb_buffer: RTL and testbench



---
 rtl/cv32e40p_wb_buffer.sv | 128 ++++++++++++
 tb/tb_cv32e40p_wb_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_wb_buffer.sv
// In-order write-back FIFO feeding register-file port B, with RAW hazard detection.
// Optional youngest-entry data forwarding is built when CV32E40P_WB_FWD_EN is defined.
module cv32e40p_wb_buffer #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [ADDR_WIDTH-1:0]        in_addr_i,
   input  logic [DATA_WIDTH-1:0]        in_data_i,
   input  logic                         drain_en_i,
   output logic                         we_b_o,
   output logic [ADDR_WIDTH-1:0]        waddr_b_o,
   output logic [DATA_WIDTH-1:0]        wdata_b_o,
   input  logic [ADDR_WIDTH-1:0]        raddr_a_i,
   input  logic [ADDR_WIDTH-1:0]        raddr_b_i,
   input  logic [ADDR_WIDTH-1:0]        raddr_c_i,
   output logic                         hit_a_o,
   output logic                         hit_b_o,
   output logic                         hit_c_o,
   output logic [DATA_WIDTH-1:0]        fwd_data_a_o,
   output logic [DATA_WIDTH-1:0]        fwd_data_b_o,
   output logic [DATA_WIDTH-1:0]        fwd_data_c_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0]      mem_vld;
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_next;
   logic                  accept;
   logic                  store;
   logic                  drain;

   function automatic logic hit_of(input logic [ADDR_WIDTH-1:0] raddr);
      logic h;
      h = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (mem_vld[k] && (mem_addr[k] == raddr)) h = 1'b1;
      end
      return h && (raddr != '0);
   endfunction

`ifdef CV32E40P_WB_FWD_EN
   // Walk oldest to youngest so the last match seen is the youngest.
   function automatic logic [DATA_WIDTH-1:0] fwd_of(input logic [ADDR_WIDTH-1:0] raddr);
      logic [DATA_WIDTH-1:0] d;
      logic [PTR_W-1:0]      idx;
      d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rptr + PTR_W'(k);
         if (mem_vld[idx] && (mem_addr[idx] == raddr) && (raddr != '0)) d = mem_data[idx];
      end
      return d;
   endfunction
`endif

   assign in_ready_o = (count != CNT_W'(DEPTH));
   assign accept     = in_valid_i & in_ready_o;
   assign store      = accept & (in_addr_i != '0);
   assign drain      = (count != '0) & drain_en_i;

   always_comb begin
      count_next = count;
      case ({store, drain})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         mem_vld <= '0;
      end else begin
         if (drain) begin
            mem_vld[rptr] <= 1'b0;
            rptr          <= rptr + PTR_W'(1);
         end
         if (store) begin
            mem_vld[wptr] <= 1'b1;
            wptr          <= wptr + PTR_W'(1);
         end
         count <= count_next;
      end
   end

   // Payload storage is not reset; the valid bits qualify every read of it.
   always_ff @(posedge clk) begin
      if (store) begin
         mem_addr[wptr] <= in_addr_i;
         mem_data[wptr] <= in_data_i;
      end
   end

   assign we_b_o    = drain;
   assign waddr_b_o = (count != '0) ? mem_addr[rptr] : '0;
   assign wdata_b_o = (count != '0) ? mem_data[rptr] : '0;
   assign count_o   = count;

   always_comb begin
      hit_a_o = hit_of(raddr_a_i);
      hit_b_o = hit_of(raddr_b_i);
      hit_c_o = hit_of(raddr_c_i);
`ifdef CV32E40P_WB_FWD_EN
      fwd_data_a_o = fwd_of(raddr_a_i);
      fwd_data_b_o = fwd_of(raddr_b_i);
      fwd_data_c_o = fwd_of(raddr_c_i);
`else
      fwd_data_a_o = '0;
      fwd_data_b_o = '0;
      fwd_data_c_o = '0;
`endif
   end

endmodule

// File: tb/tb_cv32e40p_wb_buffer.sv
// Directed self-checking bench for cv32e40p_wb_buffer (default DEPTH=4).
// Forwarding expectations follow CV32E40P_WB_FWD_EN as seen by the bench.
module tb_cv32e40p_wb_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [5:0]  in_addr_i;
   logic [31:0] in_data_i;
   logic        drain_en_i;
   logic        we_b_o;
   logic [5:0]  waddr_b_o;
   logic [31:0] wdata_b_o;
   logic [5:0]  raddr_a_i, raddr_b_i, raddr_c_i;
   logic        hit_a_o, hit_b_o, hit_c_o;
   logic [31:0] fwd_data_a_o, fwd_data_b_o, fwd_data_c_o;
   logic [2:0]  count_o;

   int checks   = 0;
   int failures = 0;

   cv32e40p_wb_buffer dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_addr_i(in_addr_i), .in_data_i(in_data_i),
      .drain_en_i(drain_en_i),
      .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
      .hit_a_o(hit_a_o), .hit_b_o(hit_b_o), .hit_c_o(hit_c_o),
      .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o), .fwd_data_c_o(fwd_data_c_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] fwd_exp;
      rst = 1'b1; in_valid_i = 1'b1; in_addr_i = 6'd7; in_data_i = 32'h77;
      drain_en_i = 1'b1; raddr_a_i = 6'd7; raddr_b_i = 6'd0; raddr_c_i = 6'd0;
      #1;
      // Reset held for two cycles with traffic offered
      tick(); tick();
      rst = 1'b0; in_valid_i = 1'b0;
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_ready", in_ready_o, 1);
      chk("rst_we", we_b_o, 0);
      chk("rst_waddr", waddr_b_o, 0);
      chk("rst_wdata", wdata_b_o, 0);
      chk("rst_hits", {hit_a_o, hit_b_o, hit_c_o}, 0);
      chk("rst_fwd_a", fwd_data_a_o, 0);

      // Single write with drain enabled
      raddr_a_i = 6'd5;
      in_valid_i = 1'b1; in_addr_i = 6'd5; in_data_i = 32'hDEADBEEF; drain_en_i = 1'b1;
      #1;
      chk("single_ready", in_ready_o, 1);
      chk("single_hit_accept_cycle", hit_a_o, 0);
      chk("single_we_accept_cycle", we_b_o, 0);
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("single_we", we_b_o, 1);
      chk("single_waddr", waddr_b_o, 5);
      chk("single_wdata", wdata_b_o, 32'hDEADBEEF);
      chk("single_hit_draining", hit_a_o, 1);
      tick();
      chk("single_count_after", count_o, 0);
      chk("single_we_after", we_b_o, 0);
      chk("single_hit_after", hit_a_o, 0);

      // Fill with drain disabled: fifth offer must be refused
      drain_en_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         in_valid_i = 1'b1; in_addr_i = 6'(i); in_data_i = 32'h100 + 32'(i);
         #1;
         chk($sformatf("fill_ready_%0d", i), in_ready_o, (i <= 4) ? 1 : 0);
         tick();
      end
      in_valid_i = 1'b0;
      #1;
      chk("fill_count", count_o, 4);
      chk("fill_ready_full", in_ready_o, 0);
      drain_en_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("drain_we_%0d", i), we_b_o, 1);
         chk($sformatf("drain_waddr_%0d", i), waddr_b_o, i);
         chk($sformatf("drain_wdata_%0d", i), wdata_b_o, 32'h100 + i);
         tick();
         if (i == 1) chk("drain_ready_reassert", in_ready_o, 1);
      end
      chk("drain_count_empty", count_o, 0);

      // Two writes to f1 (addr 33); youngest wins for forwarding
      drain_en_i = 1'b0;
      in_valid_i = 1'b1; in_addr_i = 6'd33; in_data_i = 32'h11;
      tick();
      in_data_i = 32'h22;
      tick();
      in_valid_i = 1'b0;
      raddr_a_i = 6'd0; raddr_b_i = 6'd33; raddr_c_i = 6'd1;
      #1;
`ifdef CV32E40P_WB_FWD_EN
      fwd_exp = 32'h22;
`else
      fwd_exp = 32'h0;
`endif
      chk("haz_hit_b", hit_b_o, 1);
      chk("haz_hit_a_x0", hit_a_o, 0);
      chk("haz_hit_c_bank", hit_c_o, 0);
      chk("haz_fwd_b", fwd_data_b_o, fwd_exp);
      chk("haz_fwd_c", fwd_data_c_o, 0);
      drain_en_i = 1'b1;
      #1;
      chk("haz_drain1_wdata", wdata_b_o, 32'h11);
      tick();
      chk("haz_drain2_wdata", wdata_b_o, 32'h22);
      chk("haz_fwd_b_after1", fwd_data_b_o, fwd_exp);
      tick();
      chk("haz_count_empty", count_o, 0);
      chk("haz_hit_b_empty", hit_b_o, 0);

      // x0 is acknowledged but dropped; f0 (32) is stored
      drain_en_i = 1'b0;
      in_valid_i = 1'b1; in_addr_i = 6'd0; in_data_i = 32'h55;
      #1;
      chk("x0_ready", in_ready_o, 1);
      tick();
      in_addr_i = 6'd32; in_data_i = 32'h66;
      #1;
      chk("x0_count", count_o, 0);
      tick();
      in_valid_i = 1'b0; raddr_a_i = 6'd32;
      #1;
      chk("f0_count", count_o, 1);
      chk("f0_hit", hit_a_o, 1);
      drain_en_i = 1'b1;
      #1;
      chk("f0_waddr", waddr_b_o, 32);
      tick();

      // Ten back-to-back writes with continuous drain, wrapping pointers
      for (int i = 0; i < 10; i++) begin
         in_valid_i = 1'b1; in_addr_i = 6'(10 + i); in_data_i = 32'hA00 + 32'(i);
         #1;
         chk($sformatf("stream_ready_%0d", i), in_ready_o, 1);
         if (i > 0) begin
            chk($sformatf("stream_we_%0d", i), we_b_o, 1);
            chk($sformatf("stream_waddr_%0d", i), waddr_b_o, 10 + i - 1);
            chk($sformatf("stream_wdata_%0d", i), wdata_b_o, 32'hA00 + i - 1);
            chk($sformatf("stream_count_%0d", i), count_o, 1);
         end
         tick();
      end
      in_valid_i = 1'b0;
      #1;
      chk("stream_last_waddr", waddr_b_o, 19);
      chk("stream_last_wdata", wdata_b_o, 32'hA09);
      tick();
      chk("stream_empty", count_o, 0);

      // Full buffer: drain one, then accept and drain concurrently
      drain_en_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_i = 1'b1; in_addr_i = 6'(20 + i); in_data_i = 32'hB00 + 32'(20 + i);
         tick();
      end
      in_addr_i = 6'd24; in_data_i = 32'hB24;
      #1;
      chk("full_count", count_o, 4);
      chk("full_ready", in_ready_o, 0);
      drain_en_i = 1'b1;
      #1;
      chk("full_drain_waddr", waddr_b_o, 20);
      tick();
      chk("full_ready_after_drain", in_ready_o, 1);
      chk("full_count_3", count_o, 3);
      chk("full_concurrent_waddr", waddr_b_o, 21);
      tick();
      chk("full_concurrent_count", count_o, 3);
      drain_en_i = 1'b0;
      in_addr_i = 6'd25; in_data_i = 32'hB25;
      tick();
      in_valid_i = 1'b0;
      #1;
      chk("full_refill_count", count_o, 4);
      drain_en_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("full_order_waddr_%0d", i), waddr_b_o, 22 + i);
         chk($sformatf("full_order_wdata_%0d", i), wdata_b_o, (i < 2) ? (32'hB16 + i) : (32'hB24 + i - 2));
         tick();
      end
      chk("full_final_empty", count_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
